// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file write port between the MEM (load)
// writeback path and the ALU writeback path. MEM wins by default; a wait
// counter boosts the ALU once it has lost MAX_WAIT consecutive cycles.
//
// Handshake: a transfer happens in any cycle where valid && ready. Ready is
// combinational from stall, both valids and the wait counter, never from a
// requester's rd/data. A requester holds valid/rd/data stable until accepted.
// The winner's {rd, data} lands on the registered write port one cycle later.
module rf_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              alu_boost
);

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic              mem_acc;
  logic              alu_acc;

  assign alu_boost = (wait_cnt_q == MAX_WAIT_C);

  // Grant: stall blocks everything, a boosted ALU beats MEM, otherwise MEM first.
  always_comb begin
    mem_ready = 1'b0;
    alu_ready = 1'b0;
    if (!stall) begin
      if (alu_boost && alu_valid) begin
        alu_ready = 1'b1;
      end else if (mem_valid) begin
        mem_ready = 1'b1;
      end else begin
        alu_ready = alu_valid;
      end
    end
  end

  assign mem_acc = mem_valid && mem_ready;
  assign alu_acc = alu_valid && alu_ready;

  // Next-state: wait counter and the write-port registers.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;

    // No pending ALU request means nothing is starving.
    if (!alu_valid || alu_acc) begin
      wait_cnt_d = '0;
    end else if (!stall && (wait_cnt_q < MAX_WAIT_C)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    // Writes to register 0 are consumed but never enable the write port.
    if (mem_acc) begin
      rf_rd_d    = mem_rd;
      rf_wdata_d = mem_data;
      rf_we_d    = (mem_rd != '0);
    end else if (alu_acc) begin
      rf_rd_d    = alu_rd;
      rf_wdata_d = alu_data;
      rf_we_d    = (alu_rd != '0);
    end
  end

  // State registers; reset drops any accepted but not yet written request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: every step states the expected grant,
// and accepted writes are queued and matched against the write port a
// cycle later.
module tb_rf_wb_arbiter;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int MAX_WAIT = 3;
  localparam int CNT_W    = 8;

  logic              clk;
  logic              rst_n;
  logic              stall;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic              alu_boost;

  rf_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .alu_boost(alu_boost)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0]        last_rd;
  logic [DATA_W-1:0]        last_data;
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit st, input bit mv, input logic [ADDR_W-1:0] mrd,
                       input logic [DATA_W-1:0] md, input bit av,
                       input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad);
    stall     = st;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
  endtask

  // One cycle: drive, check grant, predict and check the write port after the edge.
  task automatic step(input string tag, input bit st, input bit mv,
                      input logic [ADDR_W-1:0] mrd, input logic [DATA_W-1:0] md,
                      input bit av, input logic [ADDR_W-1:0] ard,
                      input logic [DATA_W-1:0] ad,
                      input bit emr, input bit ear, input bit eb);
    logic                     exp_we;
    logic [ADDR_W+DATA_W-1:0] item;
    drive(st, mv, mrd, md, av, ard, ad);
    #1;
    chk({tag, "/mem_ready"}, 64'(mem_ready), 64'(emr));
    chk({tag, "/alu_ready"}, 64'(alu_ready), 64'(ear));
    chk({tag, "/alu_boost"}, 64'(alu_boost), 64'(eb));
    exp_we = 1'b0;
    if (emr) begin
      last_rd   = mrd;
      last_data = md;
      if (mrd != '0) begin
        exp_q.push_back({mrd, md});
        exp_we = 1'b1;
      end
    end else if (ear) begin
      last_rd   = ard;
      last_data = ad;
      if (ard != '0) begin
        exp_q.push_back({ard, ad});
        exp_we = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "/rf_we"}, 64'(rf_we), 64'(exp_we));
    if (exp_we) begin
      item = exp_q.pop_front();
      chk({tag, "/rf_rd"}, 64'(rf_rd), 64'(item[ADDR_W+DATA_W-1:DATA_W]));
      chk({tag, "/rf_wdata"}, 64'(rf_wdata), 64'(item[DATA_W-1:0]));
    end else begin
      chk({tag, "/rf_rd_hold"}, 64'(rf_rd), 64'(last_rd));
      chk({tag, "/rf_wdata_hold"}, 64'(rf_wdata), 64'(last_data));
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    chk({tag, "/wait_cnt"}, 64'(dut.wait_cnt_q), 64'(exp));
  endtask

  // Directed sequence
  initial begin
    rst_n     = 1'b0;
    last_rd   = '0;
    last_data = '0;
    drive(0, 0, '0, '0, 0, '0, '0);
    #2;
    chk("reset/rf_we", 64'(rf_we), 64'd0);
    chk("reset/rf_rd", 64'(rf_rd), 64'd0);
    chk("reset/rf_wdata", 64'(rf_wdata), 64'd0);
    chk("reset/alu_boost", 64'(alu_boost), 64'd0);
    chk("reset/mem_ready", 64'(mem_ready), 64'd0);
    chk("reset/alu_ready", 64'(alu_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // T2: single ALU source
    step("t2", 0, 0, 5'd0, 32'h0, 1, 5'd5, 32'hDEADBEEF, 0, 1, 0);

    // T1: reset mid-cycle with an ALU accept pending
    drive(0, 0, '0, '0, 1, 5'd7, 32'h0000_0077);
    #1;
    chk("t1/alu_ready", 64'(alu_ready), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t1/rf_we_now", 64'(rf_we), 64'd0);
    chk("t1/rf_rd_now", 64'(rf_rd), 64'd0);
    chk("t1/rf_wdata_now", 64'(rf_wdata), 64'd0);
    @(posedge clk);
    #1;
    chk("t1/rf_we_in_reset", 64'(rf_we), 64'd0);
    drive(0, 0, '0, '0, 0, '0, '0);
    rst_n     = 1'b1;
    last_rd   = '0;
    last_data = '0;
    step("t1_idle", 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0, 0);

    // T3: continuous contention, MEM x3 then boosted ALU, twice
    for (int i = 0; i < 8; i++) begin
      step($sformatf("t3_%0d", i), 0, 1, 5'(i + 1), 32'h1000 + 32'(i),
           1, 5'd10, 32'hA000_0000 + 32'(i / 4), (i % 4) != 3, (i % 4) == 3, (i % 4) == 3);
    end
    chk_cnt("t3", 0);

    // T4: MEM write to r0, then the waiting ALU request goes next
    step("t4_mem_r0", 0, 1, 5'd0, 32'h1234, 1, 5'd9, 32'hA5A5_A5A5, 1, 0, 0);
    step("t4_alu",    0, 0, 5'd0, 32'h0,    1, 5'd9, 32'hA5A5_A5A5, 0, 1, 0);
    chk_cnt("t4", 0);

    // T5: build wait_cnt=2, stall 5 cycles, then MEM once and boosted ALU
    step("t5_a", 0, 1, 5'd3, 32'h3333, 1, 5'd4, 32'h4444, 1, 0, 0);
    step("t5_b", 0, 1, 5'd3, 32'h3334, 1, 5'd4, 32'h4444, 1, 0, 0);
    chk_cnt("t5_pre", 2);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("t5_stall%0d", i), 1, 1, 5'd3, 32'h3335, 1, 5'd4, 32'h4444, 0, 0, 0);
      chk_cnt($sformatf("t5_stall%0d", i), 2);
    end
    step("t5_mem", 0, 1, 5'd3, 32'h3335, 1, 5'd4, 32'h4444, 1, 0, 0);
    chk_cnt("t5_mem", 3);
    step("t5_alu", 0, 1, 5'd3, 32'h3336, 1, 5'd4, 32'h4444, 0, 1, 1);
    chk_cnt("t5_alu", 0);

    // T6: saturation under stall, then a dropped alu_valid clears the count
    for (int i = 0; i < 3; i++) begin
      step($sformatf("t6_mem%0d", i), 0, 1, 5'd6, 32'h6000 + 32'(i), 1, 5'd8, 32'h8888, 1, 0, 0);
    end
    chk_cnt("t6_full", 3);
    step("t6_stall", 1, 1, 5'd6, 32'h6003, 1, 5'd8, 32'h8888, 0, 0, 1);
    chk_cnt("t6_sat", 3);
    step("t6_drop", 0, 1, 5'd6, 32'h6003, 0, 5'd8, 32'h8888, 1, 0, 1);
    chk_cnt("t6_drop", 0);
    step("t6_alu_only", 0, 0, 5'd0, 32'h0, 1, 5'd31, 32'hFFFF_0001, 0, 1, 0);

    chk("final/queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
